// File: rtl/alu_seq.sv
// alu_seq: handshaked WIDTH-generic ALU with an iterative shift-add multiply,
// registered per-operation NZVC outputs and a persistent, opt-in flag register.
module alu_seq #(
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       cntrl,
    input  logic             set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out,
    output logic [3:0]       flags
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [2:0] OP_PASS_B = 3'b000;
    localparam logic [2:0] OP_ZERO   = 3'b001;
    localparam logic [2:0] OP_ADD    = 3'b010;
    localparam logic [2:0] OP_SUB    = 3'b011;
    localparam logic [2:0] OP_AND    = 3'b100;
    localparam logic [2:0] OP_OR     = 3'b101;
    localparam logic [2:0] OP_XOR    = 3'b110;
    localparam logic [2:0] OP_MUL    = 3'b111;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic                   accept_s;
    logic                   mul_done_s;

    logic                   in_ready_r;
    logic                   out_valid_r;
    logic [WIDTH-1:0]       result_r;
    logic                   negative_r;
    logic                   zero_r;
    logic                   overflow_r;
    logic                   carry_r;
    logic [3:0]             flags_r;

    logic [2*WIDTH-1:0]     mcand_r;
    logic [WIDTH-1:0]       mplier_r;
    logic [2*WIDTH-1:0]     acc_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   set_flags_r;

    logic                   sub_s;
    logic [WIDTH-1:0]       b_op_s;
    logic [WIDTH:0]         sum_s;
    logic [WIDTH-1:0]       op_res_s;
    logic                   op_ovf_s;
    logic                   op_carry_s;

    logic [2*WIDTH-1:0]     acc_sum_s;
    logic [WIDTH-1:0]       mul_res_s;
    logic                   mul_ovf_s;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign negative  = negative_r;
    assign zero      = zero_r;
    assign overflow  = overflow_r;
    assign carry_out = carry_r;
    assign flags     = flags_r;

    // Control state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode: accept in IDLE, count out the multiply, hand off in DONE.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        mul_done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    accept_s = 1'b1;
                    if (cntrl == OP_MUL) begin
                        state_nxt_s = ST_MUL;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (cnt_r == CNT_W'(WIDTH - 1)) begin
                    mul_done_s  = 1'b1;
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_MUL;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs registered from the next state so they are glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= (state_nxt_s == ST_IDLE);
            out_valid_r <= (state_nxt_s == ST_DONE);
        end
    end

    // Single-cycle ops; subtraction is A + ~B + 1 so the carry is a "no borrow" flag.
    always_comb begin
        sub_s      = 1'b0;
        b_op_s     = B;
        sum_s      = '0;
        op_res_s   = '0;
        op_ovf_s   = 1'b0;
        op_carry_s = 1'b0;
        if (cntrl == OP_SUB) begin
            sub_s  = 1'b1;
            b_op_s = ~B;
        end else begin
            sub_s  = 1'b0;
            b_op_s = B;
        end
        sum_s = {1'b0, A} + {1'b0, b_op_s} + {{WIDTH{1'b0}}, sub_s};
        case (cntrl)
            OP_PASS_B: op_res_s = B;
            OP_ZERO:   op_res_s = '0;
            OP_ADD, OP_SUB: begin
                op_res_s   = sum_s[WIDTH-1:0];
                op_carry_s = sum_s[WIDTH];
                op_ovf_s   = (A[WIDTH-1] == b_op_s[WIDTH-1]) &
                             (sum_s[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:    op_res_s = A & B;
            OP_OR:     op_res_s = A | B;
            OP_XOR:    op_res_s = A ^ B;
            default:   op_res_s = '0;
        endcase
    end

    // One shift-add step; the final step's sum is also the finished product.
    always_comb begin
        if (mplier_r[0]) begin
            acc_sum_s = acc_r + mcand_r;
        end else begin
            acc_sum_s = acc_r;
        end
        mul_res_s = acc_sum_s[WIDTH-1:0];
        mul_ovf_s = |acc_sum_s[2*WIDTH-1:WIDTH];
    end

    // Datapath: operand capture, multiply iteration, result and flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_r     <= '0;
            mplier_r    <= '0;
            acc_r       <= '0;
            cnt_r       <= '0;
            set_flags_r <= 1'b0;
            result_r    <= '0;
            negative_r  <= 1'b0;
            zero_r      <= 1'b0;
            overflow_r  <= 1'b0;
            carry_r     <= 1'b0;
            flags_r     <= 4'b0000;
        end else if (accept_s) begin
            mcand_r     <= {{WIDTH{1'b0}}, A};
            mplier_r    <= B;
            acc_r       <= '0;
            cnt_r       <= '0;
            set_flags_r <= set_flags;
            if (cntrl != OP_MUL) begin
                result_r   <= op_res_s;
                negative_r <= op_res_s[WIDTH-1];
                zero_r     <= (op_res_s == '0);
                overflow_r <= op_ovf_s;
                carry_r    <= op_carry_s;
                if (set_flags) begin
                    flags_r <= {op_res_s[WIDTH-1], (op_res_s == '0), op_ovf_s, op_carry_s};
                end else begin
                    flags_r <= flags_r;
                end
            end else begin
                result_r <= result_r;
            end
        end else if (state_r == ST_MUL) begin
            acc_r    <= acc_sum_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r + CNT_W'(1);
            if (mul_done_s) begin
                result_r   <= mul_res_s;
                negative_r <= mul_res_s[WIDTH-1];
                zero_r     <= (mul_res_s == '0);
                overflow_r <= mul_ovf_s;
                carry_r    <= 1'b0;
                if (set_flags_r) begin
                    flags_r <= {mul_res_s[WIDTH-1], (mul_res_s == '0), mul_ovf_s, 1'b0};
                end else begin
                    flags_r <= flags_r;
                end
            end else begin
                result_r <= result_r;
            end
        end else begin
            result_r <= result_r;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: a 64-bit and an 8-bit instance driven with
// directed and random operations and compared with an arithmetic reference model.
module tb_alu_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 64-bit instance signals
    logic        w_reset, w_in_valid, w_in_ready, w_set_flags, w_out_valid, w_out_ready;
    logic [63:0] w_a, w_b, w_result;
    logic [2:0]  w_cntrl;
    logic        w_negative, w_zero, w_overflow, w_carry;
    logic [3:0]  w_flags;

    // 8-bit instance signals
    logic        n_reset, n_in_valid, n_in_ready, n_set_flags, n_out_valid, n_out_ready;
    logic [7:0]  n_a, n_b, n_result;
    logic [2:0]  n_cntrl;
    logic        n_negative, n_zero, n_overflow, n_carry;
    logic [3:0]  n_flags;

    // bench copies of the persistent flag registers
    logic [3:0]  fm64, fm8;

    alu_seq #(.WIDTH(64)) dut64 (
        .clk(clk), .reset(w_reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .A(w_a), .B(w_b), .cntrl(w_cntrl), .set_flags(w_set_flags),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .result(w_result),
        .negative(w_negative), .zero(w_zero), .overflow(w_overflow),
        .carry_out(w_carry), .flags(w_flags)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(n_reset), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .A(n_a), .B(n_b), .cntrl(n_cntrl), .set_flags(n_set_flags),
        .out_valid(n_out_valid), .out_ready(n_out_ready), .result(n_result),
        .negative(n_negative), .zero(n_zero), .overflow(n_overflow),
        .carry_out(n_carry), .flags(n_flags)
    );

    // Reference: returns {N,Z,V,C, result(64)} for a w-bit ALU, from plain arithmetic.
    function automatic logic [67:0] ref_op(input int w, input logic [2:0] op,
                                           input logic [63:0] a, input logic [63:0] b);
        logic [127:0] mask, full, res;
        logic signed [129:0] sa, sb, sv, smax, smin;
        logic n, z, v, c;
        mask = (128'd1 << w) - 128'd1;
        sa = $signed({66'd0, a});
        sb = $signed({66'd0, b});
        if (a[w-1]) sa = sa - (130'sd1 <<< w);
        if (b[w-1]) sb = sb - (130'sd1 <<< w);
        smax = (130'sd1 <<< (w - 1)) - 130'sd1;
        smin = -(130'sd1 <<< (w - 1));
        v = 1'b0;
        c = 1'b0;
        full = 128'd0;
        case (op)
            3'b000: full = {64'd0, b};
            3'b001: full = 128'd0;
            3'b010: begin
                full = {64'd0, a} + {64'd0, b};
                c = (full > mask);
                sv = sa + sb;
                v = (sv > smax) || (sv < smin);
            end
            3'b011: begin
                full = {64'd0, a} - {64'd0, b};
                c = (a >= b);
                sv = sa - sb;
                v = (sv > smax) || (sv < smin);
            end
            3'b100: full = {64'd0, a & b};
            3'b101: full = {64'd0, a | b};
            3'b110: full = {64'd0, a ^ b};
            default: begin
                full = {64'd0, a} * {64'd0, b};
                v = ((full >> w) != 128'd0);
            end
        endcase
        res = full & mask;
        n = res[w-1];
        z = (res == 128'd0);
        return {n, z, v, c, res[63:0]};
    endfunction

    // Drive one op into the 64-bit instance and collect its response and latency.
    task automatic run64(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic sf, output logic [63:0] res, output logic [3:0] nzvc,
                         output int lat);
        @(negedge clk);
        w_in_valid = 1'b1; w_a = a; w_b = b; w_cntrl = op; w_set_flags = sf;
        @(posedge clk); #1;
        w_in_valid = 1'b0; w_a = {$urandom, $urandom}; w_b = {$urandom, $urandom};
        w_cntrl = 3'($urandom); w_set_flags = 1'($urandom);
        lat = 1;
        while (!w_out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (w_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL timeout64 out_valid=%b required 1", w_out_valid);
        end
        res = w_result;
        nzvc = {w_negative, w_zero, w_overflow, w_carry};
        w_out_ready = 1'b1;
        @(posedge clk); #1;
        w_out_ready = 1'b0;
    endtask

    // Same as run64 for the 8-bit instance.
    task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic sf, output logic [7:0] res, output logic [3:0] nzvc,
                        output int lat);
        @(negedge clk);
        n_in_valid = 1'b1; n_a = a; n_b = b; n_cntrl = op; n_set_flags = sf;
        @(posedge clk); #1;
        n_in_valid = 1'b0; n_a = 8'($urandom); n_b = 8'($urandom);
        n_cntrl = 3'($urandom); n_set_flags = 1'($urandom);
        lat = 1;
        while (!n_out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (n_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL timeout8 out_valid=%b required 1", n_out_valid);
        end
        res = n_result;
        nzvc = {n_negative, n_zero, n_overflow, n_carry};
        n_out_ready = 1'b1;
        @(posedge clk); #1;
        n_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        w_reset = 1'b1; n_reset = 1'b1;
        w_in_valid = 1'b0; w_out_ready = 1'b0; w_a = 64'd0; w_b = 64'd0; w_cntrl = 3'd0; w_set_flags = 1'b0;
        n_in_valid = 1'b0; n_out_ready = 1'b0; n_a = 8'd0; n_b = 8'd0; n_cntrl = 3'd0; n_set_flags = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        w_reset = 1'b0; n_reset = 1'b0;
        fm64 = 4'b0000; fm8 = 4'b0000;
        checks++;
        if ({w_in_ready, w_out_valid, w_result, w_negative, w_zero, w_overflow, w_carry, w_flags} !==
            {1'b1, 1'b0, 64'd0, 4'b0000, 4'b0000}) begin
            errors++;
            $display("FAIL reset64 rdy=%b vld=%b res=%h nzvc=%b%b%b%b flags=%b required rdy=1 vld=0 zeros",
                     w_in_ready, w_out_valid, w_result, w_negative, w_zero, w_overflow, w_carry, w_flags);
        end
        checks++;
        if ({n_in_ready, n_out_valid, n_result, n_flags} !== {1'b1, 1'b0, 8'd0, 4'b0000}) begin
            errors++;
            $display("FAIL reset8 rdy=%b vld=%b res=%h flags=%b required 1 0 00 0000",
                     n_in_ready, n_out_valid, n_result, n_flags);
        end
    endtask

    task automatic test_add_sub();
        logic [63:0] res; logic [3:0] nzvc; int lat;
        run64(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, res, nzvc, lat);
        fm64 = 4'b1010;
        checks++;
        if (lat != 1 || res !== 64'h8000_0000_0000_0000 || nzvc !== 4'b1010 || w_flags !== 4'b1010) begin
            errors++;
            $display("FAIL add_ovf lat=%0d res=%h nzvc=%b flags=%b required 1 8000000000000000 1010 1010",
                     lat, res, nzvc, w_flags);
        end
        run64(3'b011, 64'd5, 64'd5, 1'b0, res, nzvc, lat);
        checks++;
        if (lat != 1 || res !== 64'd0 || nzvc !== 4'b0101 || w_flags !== 4'b1010) begin
            errors++;
            $display("FAIL sub_eq lat=%0d res=%h nzvc=%b flags=%b required 1 0 0101 1010",
                     lat, res, nzvc, w_flags);
        end
    endtask

    task automatic test_logic_ops();
        logic [63:0] res; logic [3:0] nzvc; int lat;
        logic [2:0]  ops [5];
        logic [63:0] exp [5];
        ops = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110};
        exp = '{64'h0FF0, 64'h0, 64'h00F0, 64'hFFF0, 64'hFF00};
        for (int i = 0; i < 5; i++) begin
            run64(ops[i], 64'hF0F0, 64'h0FF0, 1'b0, res, nzvc, lat);
            checks++;
            if (res !== exp[i] || nzvc[1:0] !== 2'b00 || nzvc[2] !== (exp[i] == 64'd0) || lat != 1) begin
                errors++;
                $display("FAIL logic_op%b res=%h nzvc=%b lat=%0d required res=%h VC=00 lat=1",
                         ops[i], res, nzvc, lat, exp[i]);
            end
        end
    endtask

    task automatic test_mul8();
        logic [7:0] res; logic [3:0] nzvc; int lat;
        run8(3'b111, 8'd15, 8'd17, 1'b1, res, nzvc, lat);
        fm8 = 4'b1000;
        checks++;
        if (lat != 9 || res !== 8'hFF || nzvc !== 4'b1000 || n_flags !== fm8) begin
            errors++;
            $display("FAIL mul8_255 lat=%0d res=%h nzvc=%b flags=%b required 9 ff 1000 1000",
                     lat, res, nzvc, n_flags);
        end
        run8(3'b111, 8'd16, 8'd16, 1'b0, res, nzvc, lat);
        checks++;
        if (lat != 9 || res !== 8'h00 || nzvc !== 4'b0110 || n_flags !== fm8) begin
            errors++;
            $display("FAIL mul8_256 lat=%0d res=%h nzvc=%b flags=%b required 9 00 0110 1000",
                     lat, res, nzvc, n_flags);
        end
        run8(3'b111, 8'd0, 8'd0, 1'b1, res, nzvc, lat);
        fm8 = 4'b0100;
        checks++;
        if (lat != 9 || res !== 8'h00 || nzvc !== 4'b0100 || n_flags !== fm8) begin
            errors++;
            $display("FAIL mul8_zero lat=%0d res=%h nzvc=%b flags=%b required 9 00 0100 0100",
                     lat, res, nzvc, n_flags);
        end
    endtask

    task automatic test_random();
        logic [63:0] a, b, res64; logic [7:0] res8; logic [3:0] nzvc; int lat;
        logic [2:0] op; logic sf; logic [67:0] m;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom); sf = 1'($urandom);
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            if (i % 8 == 1) a = 64'h8000_0000_0000_0000;
            if (i % 8 == 2) b = 64'hFFFF_FFFF_FFFF_FFFF;
            if (i % 8 == 3) b = a;
            if (op == 3'b111 && i % 2 == 0) b = b & 64'hFF;
            m = ref_op(64, op, a, b);
            if (sf) fm64 = m[67:64];
            run64(op, a, b, sf, res64, nzvc, lat);
            checks++;
            if (res64 !== m[63:0] || nzvc !== m[67:64] || w_flags !== fm64 ||
                lat != ((op == 3'b111) ? 65 : 1)) begin
                errors++;
                $display("FAIL rand64 op=%b a=%h b=%h res=%h nzvc=%b flags=%b lat=%0d required %h %b %b",
                         op, a, b, res64, nzvc, w_flags, lat, m[63:0], m[67:64], fm64);
            end
            op = 3'($urandom); sf = 1'($urandom);
            a = {56'd0, 8'($urandom)}; b = {56'd0, 8'($urandom)};
            m = ref_op(8, op, a, b);
            if (sf) fm8 = m[67:64];
            run8(op, a[7:0], b[7:0], sf, res8, nzvc, lat);
            checks++;
            if (res8 !== m[7:0] || nzvc !== m[67:64] || n_flags !== fm8 ||
                lat != ((op == 3'b111) ? 9 : 1)) begin
                errors++;
                $display("FAIL rand8 op=%b a=%h b=%h res=%h nzvc=%b flags=%b lat=%0d required %h %b %b",
                         op, a[7:0], b[7:0], res8, nzvc, n_flags, lat, m[7:0], m[67:64], fm8);
            end
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        w_in_valid = 1'b1; w_a = 64'd10; w_b = 64'd20; w_cntrl = 3'b010; w_set_flags = 1'b1;
        @(posedge clk); #1;
        fm64 = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            w_a = {$urandom, $urandom}; w_cntrl = 3'b001;
            @(posedge clk); #1;
            checks++;
            if (w_result !== 64'd30 || w_in_ready !== 1'b0 || w_out_valid !== 1'b1 || w_flags !== fm64) begin
                errors++;
                $display("FAIL stall%0d res=%h rdy=%b vld=%b flags=%b required 1e 0 1 %b",
                         i, w_result, w_in_ready, w_out_valid, w_flags, fm64);
            end
        end
        w_out_ready = 1'b1;
        @(posedge clk); #1;
        w_out_ready = 1'b0;
        checks++;
        if (w_in_ready !== 1'b1 || w_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL handoff rdy=%b vld=%b required 1 0", w_in_ready, w_out_valid);
        end
        w_in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (w_in_ready !== 1'b1 || w_out_valid !== 1'b0 || w_result !== 64'd30) begin
            errors++;
            $display("FAIL post_handoff rdy=%b vld=%b res=%h required 1 0 1e",
                     w_in_ready, w_out_valid, w_result);
        end
    endtask

    task automatic test_reset_mid_mul();
        logic [63:0] res; logic [3:0] nzvc; int lat;
        @(negedge clk);
        w_in_valid = 1'b1; w_a = 64'hFFFF_0000_1234_5678; w_b = 64'hFFFF_FFFF_0000_0003;
        w_cntrl = 3'b111; w_set_flags = 1'b1;
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        checks++;
        if (w_out_valid !== 1'b0 || w_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_mul vld=%b rdy=%b required 0 0", w_out_valid, w_in_ready);
        end
        w_reset = 1'b1;
        @(posedge clk); #1;
        w_reset = 1'b0;
        fm64 = 4'b0000;
        checks++;
        if (w_out_valid !== 1'b0 || w_in_ready !== 1'b1 || w_flags !== 4'b0000) begin
            errors++;
            $display("FAIL mul_abort vld=%b rdy=%b flags=%b required 0 1 0000",
                     w_out_valid, w_in_ready, w_flags);
        end
        run64(3'b010, 64'd2, 64'd3, 1'b0, res, nzvc, lat);
        checks++;
        if (lat != 1 || res !== 64'd5 || nzvc !== 4'b0000 || w_flags !== 4'b0000) begin
            errors++;
            $display("FAIL add_after_abort lat=%0d res=%h nzvc=%b flags=%b required 1 5 0000 0000",
                     lat, res, nzvc, w_flags);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_logic_ops();
        test_mul8();
        test_backpressure();
        test_random();
        test_reset_mid_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the datapath's single-cycle 64-bit ALU; WIDTH-generic.
- Adds an iterative shift-add multiply on the previously unused 3'b111 opcode.
- Adds registered per-operation flags and a persistent NZVC flag register, updated only when requested (S-bit style).
- Sits between register-read and writeback in the multi-cycle CPU; the control FSM stalls on in_ready/out_valid.

Parameters:
- WIDTH, 64, operand/result width in bits; legal range 4..64.
- CNT_W, $clog2(WIDTH)+1, width of the multiply iteration counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands/op presented.
- in_ready  output  1  block can accept an operation.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- cntrl  input  3  opcode: 000 pass B, 001 zero, 010 add, 011 sub, 100 and, 101 or, 110 xor, 111 mul (unsigned, low WIDTH bits).
- set_flags  input  1  when high at accept, this op updates the flags register.
- out_valid  output  1  result and per-op flags valid.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  operation result; held while out_valid=1.
- negative  output  1  result[WIDTH-1] of this op.
- zero  output  1  result == 0 for this op.
- overflow  output  1  add/sub: signed overflow; mul: upper product half != 0; other ops: 0.
- carry_out  output  1  add/sub: carry out of MSB (sub computed as A + ~B + 1); other ops: 0.
- flags  output  4  persistent {N,Z,V,C} register.

Behaviour:
- Reset, synchronous, dominates all other inputs: state=IDLE, in_ready=1, out_valid=0, result=0, negative=zero=overflow=carry_out=0, flags=4'b0000. Reset mid-MUL or in DONE aborts the op; no flag update occurs.
- FSM states IDLE, MUL, DONE.
- IDLE:
  - in_ready=1.
  - Accept on in_valid & in_ready: latch A, B, cntrl, set_flags.
  - cntrl != 111: result and per-op flags computed and registered on the accept edge; go to DONE. Latency is 1 edge.
  - cntrl == 111: clear accumulator and counter; go to MUL.
- MUL:
  - in_ready=0, out_valid=0.
  - Each edge: if multiplier LSB=1, add the shifted multiplicand to a 2*WIDTH-bit accumulator; shift the multiplicand left and the multiplier right; counter+1.
  - After WIDTH iterations, register result = acc[WIDTH-1:0] and overflow = |acc[2*WIDTH-1:WIDTH]; go to DONE.
  - Accept-to-out_valid latency is exactly WIDTH+1 edges.
  - An operand of 0 still takes the full latency; there is no early exit.
- DONE:
  - out_valid=1, in_ready=0; result and per-op flags stable.
  - On out_valid & out_ready: go to IDLE, out_valid=0 next cycle.
  - No back-to-back accept in the same cycle as the handoff; in_ready rises the cycle after handoff.
- Flag register:
  - Written with {negative, zero, overflow, carry_out} on the edge that enters DONE, only if the latched set_flags=1; otherwise held.
  - Unchanged while stalled in DONE.
- Arithmetic:
  - Add/sub use a WIDTH+1-bit sum; the MSB is the carry.
  - Overflow is (A[msb]==B'[msb]) & (sum[msb]!=A[msb]), where B' is ~B for sub.
  - Results are modulo 2^WIDTH.
  - Logic ops and pass ops never set V or C.
- Inputs are ignored while in_ready=0. A, B, and cntrl may change freely after accept.

Test Plan:
- WIDTH=64, add A=64'h7FFF_FFFF_FFFF_FFFF, B=1, set_flags=1 -> out_valid after 1 edge; result=64'h8000_0000_0000_0000, N=1, Z=0, V=1, C=0; flags=4'b1010.
- Sub A=5, B=5, set_flags=0 -> result=0, zero=1, carry_out=1, overflow=0; flags keep the prior 4'b1010.
- WIDTH=8, mul A=8'd15, B=8'd17 -> out_valid exactly 9 edges after accept; result=8'hFF, overflow=0. Then A=8'd16, B=8'd16 -> result=8'h00, zero=1, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and changing A -> result stable, in_ready=0, nothing accepted; out_ready=1 -> handoff, in_ready=1 the next cycle.
- Assert reset at iteration 30 of a WIDTH=64 mul -> next cycle out_valid=0, in_ready=1, flags=0; the following add of 2+3 returns 5 after 1 edge.
- Opcodes 000/001/100/101/110 with A=64'hF0F0, B=64'h0FF0 -> results 0FF0, 0, 00F0, FFF0, FF00; V=C=0 for each.
